// File: rtl/imm_narrow.sv
// imm_narrow: narrows an 8-bit signed value to 2 bits, either saturating or
// wrapping, behind a single-stage valid/ready output register. Keeps a
// saturating count of accepted items that were clamped or lost information.
module imm_narrow (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_data,
  output logic       out_sat,
  input  logic       clr_count,
  output logic [7:0] sat_count
);

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  mode_e             mode;
  logic signed [7:0] sdata;
  logic              above_range;
  logic              below_range;
  logic              wrap_lossy;
  logic [1:0]        nxt_data;
  logic              nxt_sat;
  logic              in_xfer;

  assign mode     = mode_e'(in_mode);
  assign sdata    = in_data;
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Narrowing datapath: signed range test for saturation, sign-extension test for wrap loss
  always_comb begin
    above_range = sdata > 8'sd1;
    below_range = sdata < -8'sd2;
    wrap_lossy  = in_data[7:1] != {7{in_data[1]}};
    nxt_data    = in_data[1:0];
    nxt_sat     = 1'b0;
    unique case (mode)
      MODE_SAT: begin
        if (above_range) begin
          nxt_data = 2'b01;
          nxt_sat  = 1'b1;
        end else if (below_range) begin
          nxt_data = 2'b10;
          nxt_sat  = 1'b1;
        end
      end
      MODE_WRAP: begin
        nxt_data = in_data[1:0];
        nxt_sat  = wrap_lossy;
      end
      default: begin
        nxt_data = in_data[1:0];
        nxt_sat  = 1'b0;
      end
    endcase
  end

  // Output register: load on input transfer, drop valid on a bare output transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= nxt_data;
      out_sat   <= nxt_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturation counter: clear wins over increment, sticks at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (in_xfer && nxt_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_narrow.sv
// Scoreboard bench for imm_narrow: the driver pushes the expected result on
// each input transfer; the monitor pops and compares on each output transfer.
module tb_imm_narrow;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       out_sat;
  logic       clr_count;
  logic [7:0] sat_count;

  int unsigned checks;
  int unsigned errors;
  logic [2:0]  sb[$];
  int unsigned n_in;
  int unsigned n_out;

  imm_narrow dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .clr_count (clr_count),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sat, data} from plain signed arithmetic
  function automatic logic [2:0] model(input logic [7:0] d, input logic m);
    int v;
    logic [1:0] lo2;
    v   = int'($signed(d));
    lo2 = d[1:0];
    if (!m) begin
      if (v > 1)       return 3'b1_01;
      else if (v < -2) return 3'b1_10;
      else             return {1'b0, lo2};
    end
    return {((v > 1) || (v < -2)), lo2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output transfer against the scoreboard head
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", {29'd0, out_sat, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_sat_data", {29'd0, out_sat, out_data}, {29'd0, sb.pop_front()});
      end
    end
  end

  // Present one value until accepted; push expectation on acceptance
  task automatic send(input logic [7:0] d, input logic m);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int unsigned i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d, m));
        n_in++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] v8;

  initial begin
    checks    = 0;
    errors    = 0;
    n_in      = 0;
    n_out     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {30'd0, out_data},  32'd0);
    check("rst_out_sat",   {31'd0, out_sat},   32'd0);
    check("rst_sat_count", {24'd0, sat_count}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Saturate sweep 0x80..0x7F, back to back
    for (int unsigned i = 0; i < 256; i++) begin
      v8 = 8'h80 + 8'(i);
      send(v8, 1'b0);
    end
    drain();
    check("sweep_sat_count", {24'd0, sat_count}, 32'd252);

    // Hand-picked saturate boundaries and wrap vectors
    send(8'h02, 1'b0);
    send(8'hFE, 1'b0);
    send(8'hFD, 1'b0);
    send(8'h06, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h7D, 1'b1);
    send(8'h80, 1'b1);
    drain();

    // Backpressure: one result held while a second value waits
    send(8'h01, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h40;
    in_mode   = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data",  {30'd0, out_data},  32'd1);
      check("bp_out_sat",   {31'd0, out_sat},   32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h40, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      v8 = 8'(i) - 8'd4;
      send(v8, i[0]);
    end
    drain();
    check("bp_no_loss_dup", n_out, n_in);

    // Counter saturation and clear-over-increment
    clr_count = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    check("clr_idle", {24'd0, sat_count}, 32'd0);
    for (int unsigned i = 0; i < 300; i++) send(8'h7F, 1'b0);
    drain();
    check("count_hold_255", {24'd0, sat_count}, 32'd255);
    clr_count = 1'b1;
    send(8'h7F, 1'b0);
    clr_count = 1'b0;
    check("clr_priority", {24'd0, sat_count}, 32'd0);
    drain();

    // Reset with a result pending
    send(8'h03, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sat_count", {24'd0, sat_count}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    sb.delete();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_ghost", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'hFC, 1'b1);
    drain();
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
